// File: rtl/lmmi_pkg.sv
// -----------------------------------------------------------------------------
// lmmi_pkg
// Shared types and default widths for the LMMI configuration sequencer.
//   lmmi_cmd_t   : one queued host command {wr, ofs, wdata}
//   seq_state_e  : transaction FSM states
// The command struct is sized from the package widths. A top level that
// overrides OFS_W/DAT_W must be built with matching package widths.
// -----------------------------------------------------------------------------
package lmmi_pkg;

  localparam int LMMI_OFS_W   = 8;
  localparam int LMMI_DAT_W   = 8;
  localparam int CMD_DEPTH_DF = 4;
  localparam int TMO_CYC_DF   = 255;

  typedef struct packed {
    logic                  wr;
    logic [LMMI_OFS_W-1:0] ofs;
    logic [LMMI_DAT_W-1:0] wdata;
  } lmmi_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RSP    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/lmmi_cmd_fifo.sv
// -----------------------------------------------------------------------------
// lmmi_cmd_fifo
// Synchronous command FIFO of lmmi_cmd_t entries.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   : write request / entry; ignored while full
//   pop               : remove head entry; ignored while empty
//   head              : current head entry (valid when !empty)
//   full, empty       : occupancy flags, derived from registered pointers only
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// -----------------------------------------------------------------------------
module lmmi_cmd_fifo
  import lmmi_pkg::*;
#(
  parameter int DEPTH = CMD_DEPTH_DF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  lmmi_cmd_t push_data,
  input  logic      pop,
  output lmmi_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  lmmi_cmd_t   mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; an entry is only read after a push wrote it,
  // so clearing it would just add reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lmmi_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// lmmi_cfg_sequencer
// Queues host register commands and issues them one at a time as LMMI
// transactions to a LIFCL hard config IP, returning read data and status.
// Ports:
//   clk, rst_n                         : clock (also the IP LMMI clock), async active-low reset
//   cmd_valid/cmd_ready                : host command handshake (cmd_ready = FIFO not full)
//   cmd_wr, cmd_ofs, cmd_wdata         : command: 1=write/0=read, offset, write data
//   rsp_valid/rsp_ready                : one response per command, held until accepted
//   rsp_rdata, rsp_err                 : read data (0 for writes), timeout abort flag
//   lmmi_request, lmmi_wr_rdn,
//   lmmi_offset, lmmi_wdata            : registered LMMI request to the IP
//   lmmi_ready, lmmi_rdata,
//   lmmi_rdata_valid                   : IP acceptance and read-data return
//   busy                               : FIFO non-empty or transaction in progress
// Build option: define LMMI_SEQ_TIMEOUT_EN to abort a transaction after
// TMO_CYC cycles without lmmi_ready / lmmi_rdata_valid (response carries
// rsp_err=1, rsp_rdata=0). Without it the sequencer waits indefinitely.
// -----------------------------------------------------------------------------
module lmmi_cfg_sequencer
  import lmmi_pkg::*;
#(
  parameter int CMD_DEPTH = CMD_DEPTH_DF,
  parameter int OFS_W     = LMMI_OFS_W,
  parameter int DAT_W     = LMMI_DAT_W,
  parameter int TMO_CYC   = TMO_CYC_DF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [OFS_W-1:0] cmd_ofs,
  input  logic [DAT_W-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             lmmi_request,
  output logic             lmmi_wr_rdn,
  output logic [OFS_W-1:0] lmmi_offset,
  output logic [DAT_W-1:0] lmmi_wdata,
  input  logic             lmmi_ready,
  input  logic [DAT_W-1:0] lmmi_rdata,
  input  logic             lmmi_rdata_valid,
  output logic             busy
);

  seq_state_e state, state_d;

  lmmi_cmd_t  push_data;
  lmmi_cmd_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       issue;
  logic       tmo_hit;

  logic             req_d;
  logic             wr_rdn_d;
  logic [OFS_W-1:0] ofs_d;
  logic [DAT_W-1:0] wdata_d;
  logic [DAT_W-1:0] rdata_d;
  logic             err_d;

  assign push_data = '{wr: cmd_wr, ofs: cmd_ofs, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;

  lmmi_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = (state == RSP);
  assign busy      = !fifo_empty || (state != IDLE);

`ifdef LMMI_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Restarts on every state change, so it measures time spent in the
  // current wait (REQ or RDWAIT) only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_d != state) begin
      tmo_cnt <= '0;
    end else if ((state == REQ) || (state == RDWAIT)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Fires in the TMO_CYC-th waiting cycle, so the request is high for
  // exactly TMO_CYC cycles before it is dropped.
  assign tmo_hit = ((state == REQ) || (state == RDWAIT)) &&
                   (tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state;
    req_d    = lmmi_request;
    wr_rdn_d = lmmi_wr_rdn;
    ofs_d    = lmmi_offset;
    wdata_d  = lmmi_wdata;
    rdata_d  = rsp_rdata;
    err_d    = rsp_err;
    issue    = 1'b0;

    unique case (state)
      IDLE: begin
        issue = !fifo_empty;
      end
      REQ: begin
        if (lmmi_ready) begin
          req_d = 1'b0;
          if (lmmi_wr_rdn) begin
            state_d = RSP;
          end else if (lmmi_rdata_valid) begin
            // Zero-latency IP: data arrives with the acceptance.
            rdata_d = lmmi_rdata;
            state_d = RSP;
          end else begin
            state_d = RDWAIT;
          end
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RDWAIT: begin
        if (lmmi_rdata_valid) begin
          rdata_d = lmmi_rdata;
          state_d = RSP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          issue   = !fifo_empty;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Launch the head command; the request appears on the pins next cycle.
    if (issue) begin
      state_d  = REQ;
      req_d    = 1'b1;
      wr_rdn_d = head.wr;
      ofs_d    = head.ofs;
      wdata_d  = head.wdata;
      rdata_d  = '0;
      err_d    = 1'b0;
    end
  end

  assign pop = issue;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lmmi_request <= 1'b0;
      lmmi_wr_rdn  <= 1'b0;
      lmmi_offset  <= '0;
      lmmi_wdata   <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state        <= state_d;
      lmmi_request <= req_d;
      lmmi_wr_rdn  <= wr_rdn_d;
      lmmi_offset  <= ofs_d;
      lmmi_wdata   <= wdata_d;
      rsp_rdata    <= rdata_d;
      rsp_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_lmmi_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lmmi_cfg_sequencer
// Directed bench for lmmi_cfg_sequencer. The initial block plays both the
// host and the config IP; each accepted command pushes its expected response
// onto a scoreboard queue, and a monitor pops and compares on every response
// handshake. Timeout scenario only runs when LMMI_SEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lmmi_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_ofs;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       lmmi_request;
  logic       lmmi_wr_rdn;
  logic [7:0] lmmi_offset;
  logic [7:0] lmmi_wdata;
  logic       lmmi_ready;
  logic [7:0] lmmi_rdata;
  logic       lmmi_rdata_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int rsp_seen = 0;
  int rsp_exp  = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  lmmi_cfg_sequencer #(
    .CMD_DEPTH (4),
    .OFS_W     (8),
    .DAT_W     (8),
    .TMO_CYC   (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_wr           (cmd_wr),
    .cmd_ofs          (cmd_ofs),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .lmmi_request     (lmmi_request),
    .lmmi_wr_rdn      (lmmi_wr_rdn),
    .lmmi_offset      (lmmi_offset),
    .lmmi_wdata       (lmmi_wdata),
    .lmmi_ready       (lmmi_ready),
    .lmmi_rdata       (lmmi_rdata),
    .lmmi_rdata_valid (lmmi_rdata_valid),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: a handshake completes at the posedge after this sample.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_extra", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        rsp_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] ofs, input logic [7:0] wd,
                          input logic [7:0] rd_exp, input logic err_exp);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_ofs   = ofs;
    cmd_wdata = wd;
    check("cmd_ready_on_push", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back('{rd_exp, err_exp});
    rsp_exp++;
  endtask

  // Act as the IP for one transaction: ready after rdly waiting cycles,
  // read data vdly cycles after ready (0 = same cycle as ready).
  task automatic serve(input logic [7:0] ofs_e, input logic wr_e, input logic [7:0] wd_e,
                       input int rdly, input int vdly, input logic [7:0] rd);
    int n = 0;
    while (!lmmi_request && n < 50) begin
      tick();
      n++;
    end
    check("req_seen", lmmi_request, 1'b1);
    check("req_ofs", lmmi_offset, ofs_e);
    check("req_dir", lmmi_wr_rdn, wr_e);
    if (wr_e) check("req_wdata", lmmi_wdata, wd_e);
    for (int i = 0; i < rdly; i++) begin
      tick();
      check("req_hold", lmmi_request, 1'b1);
      check("req_ofs_hold", lmmi_offset, ofs_e);
    end
    lmmi_ready = 1'b1;
    if (!wr_e && vdly == 0) begin
      lmmi_rdata_valid = 1'b1;
      lmmi_rdata       = rd;
    end
    tick();
    lmmi_ready       = 1'b0;
    lmmi_rdata_valid = 1'b0;
    check("req_drop", lmmi_request, 1'b0);
    if (!wr_e && vdly > 0) begin
      for (int i = 1; i < vdly; i++) begin
        lmmi_rdata = 8'hFF;
        tick();
      end
      lmmi_rdata_valid = 1'b1;
      lmmi_rdata       = rd;
      tick();
      lmmi_rdata_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    rst_n            = 1'b0;
    cmd_valid        = 1'b0;
    cmd_wr           = 1'b0;
    cmd_ofs          = '0;
    cmd_wdata        = '0;
    rsp_ready        = 1'b1;
    lmmi_ready       = 1'b0;
    lmmi_rdata       = '0;
    lmmi_rdata_valid = 1'b0;

    // Reset state.
    #12;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_request", lmmi_request, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write 0x10 <- 0xA5, ready after 2 cycles; stray rdata_valid in IDLE ignored.
    push_cmd(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    lmmi_rdata_valid = 1'b1;
    lmmi_rdata       = 8'hEE;
    tick();
    lmmi_rdata_valid = 1'b0;
    serve(8'h10, 1'b1, 8'hA5, 2, 0, 8'h00);
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_rdata", rsp_rdata, 8'h00);
    drain();

    // Read 0x22, ready immediately, data 3 cycles later.
    push_cmd(1'b0, 8'h22, 8'h00, 8'h5C, 1'b0);
    serve(8'h22, 1'b0, 8'h00, 0, 3, 8'h5C);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, 8'h5C);
    drain();

    // Zero-latency read: data with ready skips RDWAIT.
    push_cmd(1'b0, 8'h44, 8'h00, 8'hC3, 1'b0);
    serve(8'h44, 1'b0, 8'h00, 1, 0, 8'hC3);
    check("zl_rsp_rdata", rsp_rdata, 8'hC3);
    drain();

    // FIFO full: one command stuck in REQ, four fill the FIFO, fifth refused.
    push_cmd(1'b0, 8'h30, 8'h00, 8'h11, 1'b0);
    tick();
    push_cmd(1'b1, 8'h31, 8'h01, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h32, 8'h00, 8'h77, 1'b0);
    push_cmd(1'b1, 8'h33, 8'h03, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h34, 8'h00, 8'h99, 1'b0);
    check("full_cmd_ready", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_ofs   = 8'h35;
    cmd_wdata = 8'h05;
    tick();
    cmd_valid = 1'b0;
    check("full_still_full", cmd_ready, 1'b0);
    serve(8'h30, 1'b0, 8'h00, 0, 1, 8'h11);
    serve(8'h31, 1'b1, 8'h01, 0, 0, 8'h00);
    serve(8'h32, 1'b0, 8'h00, 2, 0, 8'h77);
    serve(8'h33, 1'b1, 8'h03, 0, 0, 8'h00);
    serve(8'h34, 1'b0, 8'h00, 0, 2, 8'h99);
    drain();
    tick();
    tick();
    check("full_no_stray_req", lmmi_request, 1'b0);
    check("full_idle", busy, 1'b0);
    check("rsp_count", rsp_seen, rsp_exp);

    // Response back-pressure: held stable, next command not issued.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 8'h40, 8'h00, 8'h3B, 1'b0);
    push_cmd(1'b1, 8'h41, 8'h5A, 8'h00, 1'b0);
    serve(8'h40, 1'b0, 8'h00, 0, 0, 8'h3B);
    for (int i = 0; i < 10; i++) begin
      check("stall_rsp_valid", rsp_valid, 1'b1);
      check("stall_rsp_rdata", rsp_rdata, 8'h3B);
      check("stall_no_req", lmmi_request, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    serve(8'h41, 1'b1, 8'h5A, 0, 0, 8'h00);
    drain();

`ifdef LMMI_SEQ_TIMEOUT_EN
    // Timeout: request dropped after TMO_CYC=8 cycles, then next command runs.
    push_cmd(1'b1, 8'h60, 8'h01, 8'h00, 1'b1);
    push_cmd(1'b1, 8'h61, 8'h02, 8'h00, 1'b0);
    hi = 0;
    while (!lmmi_request && hi < 20) begin
      tick();
      hi++;
    end
    hi = 0;
    while (lmmi_request && hi < 20) begin
      hi++;
      tick();
    end
    check("tmo_req_cycles", hi, 8);
    check("tmo_rsp_err", rsp_err, 1'b1);
    serve(8'h61, 1'b1, 8'h02, 0, 0, 8'h00);
    drain();
`endif

    // Reset while in RDWAIT: transaction dropped, no response afterwards.
    push_cmd(1'b0, 8'h50, 8'h00, 8'h00, 1'b0);
    hi = 0;
    while (!lmmi_request && hi < 20) begin
      tick();
      hi++;
    end
    lmmi_ready = 1'b1;
    tick();
    lmmi_ready = 1'b0;
    tick();
    check("rdwait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_request", lmmi_request, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    exp_q.delete();
    rsp_exp--;
    tick();
    rst_n = 1'b1;
    lmmi_rdata_valid = 1'b1;
    lmmi_rdata       = 8'h77;
    tick();
    lmmi_rdata_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_rsp", rsp_valid, 1'b0);
      check("post_rst_no_req", lmmi_request, 1'b0);
      tick();
    end

    // Sequencer still operational after the reset.
    push_cmd(1'b0, 8'h51, 8'h00, 8'h42, 1'b0);
    serve(8'h51, 1'b0, 8'h00, 1, 1, 8'h42);
    drain();
    check("final_rsp_count", rsp_seen, rsp_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
